// File: rtl/bennett_run_ctrl.sv
// Run-control sequencer for the Bennett ramp clock generator: RUN/STEP/HALT, cycle counting, watchdog.
// Defining BENNETT_PEAK_HOLD_EN adds a hold input that parks the generator at its ramp peak.
module bennett_run_ctrl #(
  parameter int WIDTH   = 11,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4 * WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             gen_en,
  output logic             gen_reset,
  input  logic             gen_instflag,
  input  logic             gen_mclk,
`ifdef BENNETT_PEAK_HOLD_EN
  input  logic             hold,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles_left,
  output logic             err_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_r, state_nx;
  logic [WD_W-1:0]  wd_r, wd_nx;
  logic [CNT_W-1:0] cycles_left_r, cycles_left_nx;
  logic             instflag_q_r, flag_rise_s, accept_s, wd_hit_s;
  logic             active_s, active_nx_s, parked_nx_s;
  logic             gen_en_r, gen_reset_r, busy_r, done_r, err_r;
  logic             done_nx, err_nx, gen_en_nx;

  assign cmd_ready   = (state_r == S_IDLE) | (state_r == S_RUN) | (state_r == S_ERR);
  assign accept_s    = cmd_valid & cmd_ready;
  assign flag_rise_s = gen_instflag & ~instflag_q_r;
  assign active_s    = (state_r == S_RUN) | (state_r == S_DRAIN);
  assign active_nx_s = (state_nx == S_RUN) | (state_nx == S_DRAIN);
  // A flag on the same edge as the watchdog limit proves the generator alive
  assign wd_hit_s    = gen_en_r & (wd_r == WD_LAST) & ~flag_rise_s;
  assign gen_en_nx   = active_s & active_nx_s & ~parked_nx_s;

  assign gen_en      = gen_en_r;
  assign gen_reset   = gen_reset_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign cycles_left = cycles_left_r;
  assign err_timeout = err_r;

`ifdef BENNETT_PEAK_HOLD_EN
  logic mclk_q_r, parked_r;

  // Park on an mclk rise while hold is set; stay parked until hold drops
  always_comb begin
    parked_nx_s = 1'b0;
    if (active_s) begin
      if (parked_r) begin
        parked_nx_s = hold;
      end else begin
        parked_nx_s = hold & gen_mclk & ~mclk_q_r;
      end
    end else begin
      parked_nx_s = 1'b0;
    end
  end

  // Peak-hold edge and park registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mclk_q_r <= 1'b0;
      parked_r <= 1'b0;
    end else begin
      mclk_q_r <= gen_mclk;
      parked_r <= parked_nx_s;
    end
  end
`else
  logic unused_s;
  assign unused_s    = gen_mclk;
  assign parked_nx_s = 1'b0;
`endif

  // Sequencer next state, remaining-cycle count and completion/error flags
  always_comb begin
    state_nx       = state_r;
    cycles_left_nx = cycles_left_r;
    done_nx        = 1'b0;
    err_nx         = err_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP))) begin
          state_nx       = S_START;
          cycles_left_nx = (cmd_op == OP_STEP) ? CNT_ONE : cmd_count;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_START: state_nx = S_RUN;
      S_RUN: begin
        // The final count completes before a simultaneous HALT is considered
        if (flag_rise_s && (cycles_left_r == CNT_ONE)) begin
          state_nx       = S_IDLE;
          cycles_left_nx = '0;
          done_nx        = 1'b1;
        end else if (wd_hit_s) begin
          state_nx = S_ERR;
          err_nx   = 1'b1;
        end else begin
          if (flag_rise_s && (cycles_left_r != '0)) begin
            cycles_left_nx = cycles_left_r - CNT_ONE;
          end else begin
            cycles_left_nx = cycles_left_r;
          end
          if (accept_s && (cmd_op == OP_HALT)) begin
            state_nx = S_DRAIN;
          end else begin
            state_nx = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (flag_rise_s) begin
          state_nx       = S_IDLE;
          cycles_left_nx = '0;
          done_nx        = 1'b1;
        end else if (wd_hit_s) begin
          state_nx = S_ERR;
          err_nx   = 1'b1;
        end else begin
          state_nx = S_DRAIN;
        end
      end
      S_ERR: begin
        if (accept_s && (cmd_op == OP_HALT)) begin
          state_nx       = S_IDLE;
          cycles_left_nx = '0;
          err_nx         = 1'b0;
        end else begin
          state_nx = S_ERR;
        end
      end
      default: begin
        state_nx       = S_IDLE;
        cycles_left_nx = '0;
        err_nx         = 1'b0;
      end
    endcase
  end

  // Watchdog counts enabled cycles since the last instFlag; idle states hold it at zero
  always_comb begin
    wd_nx = wd_r;
    if (flag_rise_s || !active_s) begin
      wd_nx = '0;
    end else if (gen_en_r) begin
      wd_nx = wd_r + WD_ONE;
    end else begin
      wd_nx = wd_r;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      wd_r          <= '0;
      cycles_left_r <= '0;
      instflag_q_r  <= 1'b0;
      gen_en_r      <= 1'b0;
      gen_reset_r   <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_nx;
      wd_r          <= wd_nx;
      cycles_left_r <= cycles_left_nx;
      instflag_q_r  <= gen_instflag;
      gen_en_r      <= gen_en_nx;
      gen_reset_r   <= (state_r == S_START);
      busy_r        <= (state_nx != S_IDLE);
      done_r        <= done_nx;
      err_r         <= err_nx;
    end
  end

endmodule

// File: tb/tb_bennett_run_ctrl.sv
// Directed bench for bennett_run_ctrl with a behavioural WIDTH=11 generator (instFlag every 22 enabled cycles).
module tb_bennett_run_ctrl;

  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] count;
    int          halt_at;
    bit          stall;
    int          exp_flags;
    int          exp_done;
    bit          exp_err;
    int          exp_en;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_count;
  logic        gen_en, gen_reset, instflag, mclk;
  logic        busy, done, err_timeout;
  logic [15:0] cycles_left;
  logic [4:0]  gcnt;
  logic        stall = 1'b0;
`ifdef BENNETT_PEAK_HOLD_EN
  logic        hold = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int flag_cnt = 0;
  int done_cnt = 0;
  int en_cnt = 0;
  vec_t vecs[5];
  vec_t v_post;

  bennett_run_ctrl #(.WIDTH(11), .CNT_W(16), .TIMEOUT(44)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_count(cmd_count),
    .gen_en(gen_en),
    .gen_reset(gen_reset),
    .gen_instflag(instflag),
    .gen_mclk(mclk),
`ifdef BENNETT_PEAK_HOLD_EN
    .hold(hold),
`endif
    .busy(busy),
    .done(done),
    .cycles_left(cycles_left),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural generator: one-cycle instFlag after 22 enabled cycles, mclk high on the falling ramp half
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt <= 5'd0; instflag <= 1'b0;
    end else if (gen_reset) begin
      gcnt <= 5'd0; instflag <= 1'b0;
    end else if (gen_en && !stall) begin
      if (gcnt == 5'd21) begin gcnt <= 5'd0; instflag <= 1'b1; end
      else begin gcnt <= gcnt + 5'd1; instflag <= 1'b0; end
    end else begin
      instflag <= 1'b0;
    end
  end
  assign mclk = (gcnt >= 5'd11);

  always @(negedge clk) begin
    if (instflag) flag_cnt++;
    if (done) done_cnt++;
    if (gen_en) en_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got time-out expected $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a command just after a negedge; it is accepted at the following posedge
  task automatic issue(input logic [1:0] op, input logic [15:0] cnt, input string name);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
    #1;
    chk({name, " cmd_ready"}, int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 16'd0;
  endtask

  task automatic run_vec(input vec_t v);
    int f0, d0, e0;
    bit fin;
    f0 = flag_cnt; d0 = done_cnt; e0 = en_cnt;
    stall = v.stall;
    @(negedge clk);
    issue(v.op, v.count, v.name);
    fin = 1'b0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      if (v.halt_at != 0 && n == v.halt_at) issue(OP_HALT, 16'd0, {v.name, " halt"});
      else if (!busy || err_timeout) fin = 1'b1;
    end
    chk({v.name, " completed"}, int'(fin), 1);
    @(negedge clk);
    #1;
    chk({v.name, " flags"}, flag_cnt - f0, v.exp_flags);
    chk({v.name, " done pulses"}, done_cnt - d0, v.exp_done);
    chk({v.name, " gen_en cycles"}, en_cnt - e0, v.exp_en);
    chk({v.name, " err_timeout"}, int'(err_timeout), int'(v.exp_err));
    chk({v.name, " busy"}, int'(busy), int'(v.exp_err));
    chk({v.name, " gen_en end"}, int'(gen_en), 0);
    if (!v.exp_err) chk({v.name, " cycles_left end"}, int'(cycles_left), 0);
  endtask

  initial begin
    int  exp_left, d0, f0;
    bit  pend, fin;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 16'd0;

    vecs[0] = '{"run3",      OP_RUN,  16'd3, 0,  1'b0, 3, 1, 1'b0, 67};
    vecs[1] = '{"step",      OP_STEP, 16'd7, 0,  1'b0, 1, 1, 1'b0, 23};
    vecs[2] = '{"run0_halt", OP_RUN,  16'd0, 30, 1'b0, 2, 1, 1'b0, 45};
    vecs[3] = '{"run2",      OP_RUN,  16'd2, 0,  1'b0, 2, 1, 1'b0, 45};
    vecs[4] = '{"run5_stall",OP_RUN,  16'd5, 0,  1'b1, 0, 0, 1'b1, 44};
    v_post  = '{"post_rst",  OP_RUN,  16'd2, 0,  1'b0, 2, 1, 1'b0, 45};

    repeat (3) @(negedge clk);
    chk("reset gen_en", int'(gen_en), 0);
    chk("reset gen_reset", int'(gen_reset), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset cycles_left", int'(cycles_left), 0);
    chk("reset err_timeout", int'(err_timeout), 0);
    chk("reset cmd_ready", int'(cmd_ready), 1);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Error state: RUN is accepted but ignored, only HALT leaves
    @(negedge clk);
    issue(OP_RUN, 16'd4, "err_run");
    @(negedge clk);
    chk("err after run err_timeout", int'(err_timeout), 1);
    chk("err after run busy", int'(busy), 1);
    chk("err after run gen_reset", int'(gen_reset), 0);
    issue(OP_HALT, 16'd0, "err_halt");
    @(negedge clk);
    chk("err halt err_timeout", int'(err_timeout), 0);
    chk("err halt busy", int'(busy), 0);
    stall = 1'b0;

    // Start-up sequence and per-flag countdown of a RUN of 3
    @(negedge clk);
    issue(OP_RUN, 16'd3, "trace");
    @(negedge clk);
    chk("trace busy", int'(busy), 1);
    chk("trace cycles_left start", int'(cycles_left), 3);
    chk("trace gen_reset early", int'(gen_reset), 0);
    @(negedge clk);
    chk("trace gen_reset pulse", int'(gen_reset), 1);
    chk("trace gen_en during reset", int'(gen_en), 0);
    @(negedge clk);
    chk("trace gen_reset end", int'(gen_reset), 0);
    chk("trace gen_en on", int'(gen_en), 1);
    exp_left = 3; pend = 1'b0; fin = 1'b0;
    for (int n = 0; n < 200 && !fin; n++) begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        exp_left--;
        chk("trace cycles_left", int'(cycles_left), exp_left);
        if (exp_left == 0) begin
          chk("trace done", int'(done), 1);
          chk("trace gen_en off", int'(gen_en), 0);
          chk("trace busy off", int'(busy), 0);
          fin = 1'b1;
        end else begin
          chk("trace early done", int'(done), 0);
        end
      end else if (instflag) begin
        pend = 1'b1;
      end else begin
        pend = 1'b0;
      end
    end
    chk("trace finished", int'(fin), 1);
    @(negedge clk);
    chk("trace done one cycle", int'(done), 0);

    // HALT accepted on the same edge as the final flag: completes, no drain
    @(negedge clk);
    d0 = done_cnt;
    issue(OP_RUN, 16'd1, "coinc");
    fin = 1'b0;
    for (int n = 0; n < 100 && !fin; n++) begin
      @(negedge clk);
      if (instflag) begin
        issue(OP_HALT, 16'd0, "coinc halt");
        fin = 1'b1;
      end else begin
        fin = 1'b0;
      end
    end
    chk("coinc flag seen", int'(fin), 1);
    @(negedge clk);
    chk("coinc done", int'(done), 1);
    chk("coinc busy", int'(busy), 0);
    repeat (30) @(negedge clk);
    #1;
    chk("coinc done pulses", done_cnt - d0, 1);
    chk("coinc gen_en", int'(gen_en), 0);

    // Asynchronous reset mid-ramp, then a fresh RUN
    @(negedge clk);
    issue(OP_RUN, 16'd2, "rst_run");
    repeat (10) @(negedge clk);
    chk("rst pre gen_en", int'(gen_en), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst gen_en", int'(gen_en), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst cycles_left", int'(cycles_left), 0);
    chk("rst err_timeout", int'(err_timeout), 0);
    chk("rst gen_reset", int'(gen_reset), 0);
    chk("rst done", int'(done), 0);
    chk("rst cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    run_vec(v_post);

`ifdef BENNETT_PEAK_HOLD_EN
    // Park at the peak, hold for 100 cycles without a timeout, then release
    hold = 1'b1;
    f0 = flag_cnt; d0 = done_cnt;
    @(negedge clk);
    issue(OP_RUN, 16'd1, "park");
    repeat (30) @(negedge clk);
    chk("park gen_en", int'(gen_en), 0);
    exp_left = en_cnt;
    repeat (100) @(negedge clk);
    #1;
    chk("park no enable", en_cnt - exp_left, 0);
    chk("park err_timeout", int'(err_timeout), 0);
    chk("park busy", int'(busy), 1);
    chk("park cycles_left", int'(cycles_left), 1);
    hold = 1'b0;
    fin = 1'b0;
    for (int n = 0; n < 100 && !fin; n++) begin
      @(negedge clk);
      if (!busy) fin = 1'b1;
      else fin = 1'b0;
    end
    chk("park completed", int'(fin), 1);
    @(negedge clk);
    #1;
    chk("park flags", flag_cnt - f0, 1);
    chk("park done", done_cnt - d0, 1);
    chk("park cycles_left end", int'(cycles_left), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
